imm_encode_loader: RTL and testbench
====================================

Name: imm_encode_loader

Overview:
- Reverse of the immediate-extract path: packs register, function and immediate fields into 32-bit RV32 instruction words.
- Covers I-type and B-type formats, using the same ImmSrc convention as the decode side: 1 = I-type, 0 = B-type.
- Streams the packed words into instruction memory through a write port with an auto-incrementing address.
- Used by the bench and the boot path to load programs.

Parameters:
DATA_WIDTH, 32, instruction/write-data width
ADDR_WIDTH, 32, instruction memory address width
BASE_ADDR, 32'hBFC00000, first write address after start
DEPTH, 256, maximum words per load session (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  pulse: begin a load session
finish  input  1  pulse: end the session
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle
opcode  input  7  instr[6:0]
rd  input  5  instr[11:7] (I-type only)
funct3  input  3  instr[14:12]
rs1  input  5  instr[19:15]
rs2  input  5  instr[24:20] (B-type only)
imm  input  32  signed immediate; byte offset for B-type
ImmSrc  input  1  1 = I-type, 0 = B-type
mem_we  output  1  write strobe
mem_addr  output  ADDR_WIDTH  write address
mem_wdata  output  DATA_WIDTH  packed instruction
word_count  output  $clog2(DEPTH)+1  words written this session
full  output  1  DEPTH words written
imm_err  output  1  sticky range error
done  output  1  session closed

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - Outputs: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, full=0, imm_err=0, done=0.
  - Any pending write is dropped, including a reset arriving mid-session.
- States IDLE, LOAD, FULL, DONE:
  - IDLE, on start → LOAD. Clears word_count, full, imm_err and done; next address = BASE_ADDR.
  - LOAD, when word_count reaches DEPTH → FULL.
  - LOAD or FULL, on finish → DONE.
  - DONE, on start → LOAD (clears as above).
  - start in LOAD or FULL is ignored.
- in_ready = 1 only in LOAD with full=0. A bundle is accepted when in_valid && in_ready.
- I-type packing: {imm[11:0], rs1, funct3, rd, opcode}.
  - Legal range: -2048..2047.
- B-type packing: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - Legal: even values in -4096..4094.
- Latency: one cycle. In the cycle after acceptance:
  - mem_we=1 for exactly one cycle;
  - mem_addr = current write address;
  - mem_wdata = packed word.
  - Then the address advances by 4 and word_count increments.
- Out-of-range immediate:
  - The bundle is still consumed (handshake completes).
  - No write is issued; address and count are unchanged.
  - imm_err=1 and stays set until the next start or reset.
- Back-to-back: with in_valid held high, one word is written per cycle.
- Full: when word_count becomes DEPTH, full=1 and in_ready=0 on the following cycle. No address wrap: the last write is BASE_ADDR+4*(DEPTH-1).
- finish in the same cycle as an acceptance:
  - The bundle is accepted and written normally.
  - The state moves to DONE, so no further bundles are accepted.
- done=1 throughout DONE. The final write strobe may coincide with the first DONE cycle.
- finish in IDLE is ignored.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro IMM_ENCODE_CHECKSUM_EN.
- Defined:
  - Adds output checksum [31:0], reset to 0 and cleared on start.
  - Each issued write updates it: checksum <= {checksum[30:0],checksum[31]} ^ mem_wdata.
  - Errored bundles do not update it.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, start; I-type opcode=7'h13, rd=1, funct3=0, rs1=0, imm=-1 → next cycle mem_we=1, mem_addr=32'hBFC00000, mem_wdata=32'hFFF00093, word_count=1.
2. B-type opcode=7'h63, funct3=1, rs1=1, rs2=0, imm=-4, following test 1 back-to-back → mem_addr=32'hBFC00004, mem_wdata=32'hFE009EE3, word_count=2.
3. I-type imm=2048, then B-type imm=3 → both accepted, no mem_we, imm_err=1, word_count unchanged; next legal word lands at the unchanged address; start clears imm_err.
4. DEPTH=4, in_valid held with 5 legal bundles → writes to BFC00000..BFC0000C, full=1, in_ready=0, 5th bundle never accepted; finish → done=1.
5. finish asserted together with an accepted bundle → that word written, done=1, in_ready=0 thereafter; start → word_count=0, mem_addr base.
6. rst asserted the cycle after an acceptance → no mem_we, all outputs at reset values, state IDLE (in_ready=0).

Source files
------------

// File: rtl/imm_encode_loader_if.sv
// Field-bundle and instruction-memory write bus of imm_encode_loader.
// The checksum signal exists only when IMM_ENCODE_CHECKSUM_EN is defined.
interface imm_encode_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  start;
    logic                  finish;
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [31:0]           imm;
    logic                  ImmSrc;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [CW-1:0]         word_count;
    logic                  full;
    logic                  imm_err;
    logic                  done;
`ifdef IMM_ENCODE_CHECKSUM_EN
    logic [31:0]           checksum;
`endif

    modport master (
        output start, finish, in_valid, opcode, rd, funct3, rs1, rs2, imm, ImmSrc,
        input  in_ready, mem_we, mem_addr, mem_wdata, word_count, full, imm_err, done
`ifdef IMM_ENCODE_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  start, finish, in_valid, opcode, rd, funct3, rs1, rs2, imm, ImmSrc,
        output in_ready, mem_we, mem_addr, mem_wdata, word_count, full, imm_err, done
`ifdef IMM_ENCODE_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/imm_encode_loader.sv
// Packs RV32 I/B-type fields into instruction words and streams them to instruction memory
// at auto-incrementing addresses. Define IMM_ENCODE_CHECKSUM_EN to add a rotating XOR checksum.
module imm_encode_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hBFC00000,
    parameter int                    DEPTH      = 256
) (
    input logic               clk,
    input logic               rst,
    imm_encode_loader_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // I-type immediates must fit a 12-bit signed field.
    function automatic logic imm_fits_i(input logic [31:0] v);
        return (&v[31:11]) | (~|v[31:11]);
    endfunction

    // B-type offsets are even and must fit a 13-bit signed field.
    function automatic logic imm_fits_b(input logic [31:0] v);
        return ~v[0] & ((&v[31:12]) | (~|v[31:12]));
    endfunction

    function automatic logic [31:0] pack_i(input logic [31:0] v, input logic [4:0] s1,
                                           input logic [2:0] f3, input logic [4:0] d,
                                           input logic [6:0] op);
        return {v[11:0], s1, f3, d, op};
    endfunction

    function automatic logic [31:0] pack_b(input logic [31:0] v, input logic [4:0] s2,
                                           input logic [4:0] s1, input logic [2:0] f3,
                                           input logic [6:0] op);
        return {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
    endfunction

    state_t                state_r;
    state_t                state_nx_s;
    logic                  in_ready_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic [CW-1:0]         word_count_r;
    logic                  full_r;
    logic                  imm_err_r;
    logic                  done_r;
    logic [ADDR_WIDTH-1:0] addr_r;

    logic                  accept_s;
    logic                  fits_s;
    logic                  write_s;
    logic                  err_s;
    logic                  session_start_s;
    logic                  last_slot_s;
    logic [31:0]           packed_s;

    // Handshake decode, range check and word packing for the bundle on the bus.
    always_comb begin
        fits_s   = 1'b0;
        packed_s = 32'h0000_0000;
        if (bus.ImmSrc) begin
            fits_s   = imm_fits_i(bus.imm);
            packed_s = pack_i(bus.imm, bus.rs1, bus.funct3, bus.rd, bus.opcode);
        end else begin
            fits_s   = imm_fits_b(bus.imm);
            packed_s = pack_b(bus.imm, bus.rs2, bus.rs1, bus.funct3, bus.opcode);
        end
        accept_s        = bus.in_valid & in_ready_r;
        write_s         = accept_s & fits_s;
        err_s           = accept_s & ~fits_s;
        last_slot_s     = (word_count_r == CW'(DEPTH - 1));
        session_start_s = bus.start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    end

    // Session state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; finish takes priority over filling the last slot.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nx_s = ST_LOAD;
                else           state_nx_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (bus.finish)                    state_nx_s = ST_DONE;
                else if (write_s && last_slot_s)   state_nx_s = ST_FULL;
                else                               state_nx_s = ST_LOAD;
            end
            ST_FULL: begin
                if (bus.finish) state_nx_s = ST_DONE;
                else            state_nx_s = ST_FULL;
            end
            ST_DONE: begin
                if (bus.start) state_nx_s = ST_LOAD;
                else           state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Registered outputs and write datapath; an accepted word is presented one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r   <= 1'b0;
            done_r       <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= BASE_ADDR;
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
            word_count_r <= {CW{1'b0}};
            full_r       <= 1'b0;
            imm_err_r    <= 1'b0;
            addr_r       <= BASE_ADDR;
        end else begin
            in_ready_r <= (state_nx_s == ST_LOAD);
            done_r     <= (state_nx_s == ST_DONE);
            mem_we_r   <= write_s;
            if (session_start_s) begin
                word_count_r <= {CW{1'b0}};
                full_r       <= 1'b0;
                imm_err_r    <= 1'b0;
                addr_r       <= BASE_ADDR;
                mem_addr_r   <= BASE_ADDR;
            end else if (write_s) begin
                mem_addr_r   <= addr_r;
                mem_wdata_r  <= DATA_WIDTH'(packed_s);
                addr_r       <= addr_r + ADDR_WIDTH'(4);
                word_count_r <= word_count_r + CW'(1);
                full_r       <= last_slot_s;
            end else if (err_s) begin
                imm_err_r <= 1'b1;
            end else begin
                imm_err_r <= imm_err_r;
            end
        end
    end

`ifdef IMM_ENCODE_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Rotate-and-XOR over every issued word; errored bundles leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_r <= 32'h0000_0000;
        end else if (session_start_s) begin
            checksum_r <= 32'h0000_0000;
        end else if (write_s) begin
            checksum_r <= {checksum_r[30:0], checksum_r[31]} ^ packed_s;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign bus.checksum = checksum_r;
`endif

    assign bus.in_ready   = in_ready_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.word_count = word_count_r;
    assign bus.full       = full_r;
    assign bus.imm_err    = imm_err_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_imm_encode_loader.sv
// Self-checking bench for imm_encode_loader: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a session-level behavioural model.
module tb_imm_encode_loader;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hBFC00000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_encode_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) bus ();

    imm_encode_loader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: a session is open between start and finish and holds DEPTH words.
    bit          m_started, m_closed, m_ready, m_we, m_full, m_err, m_done;
    int          m_count;
    logic [31:0] m_addr, m_wdata, m_cks;

    function automatic bit legal(input bit is_i, input logic [31:0] v);
        int si;
        si = $signed(v);
        if (is_i) return (si >= -2048) && (si <= 2047);
        return (si >= -4096) && (si <= 4094) && ((si % 2) == 0);
    endfunction

    function automatic logic [31:0] encode(input bit is_i, input logic [31:0] v,
                                           input logic [6:0] op, input logic [4:0] d,
                                           input logic [2:0] f3, input logic [4:0] s1,
                                           input logic [4:0] s2);
        logic [31:0] w;
        w = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
        if (is_i) begin
            w = w | (32'(d) << 7) | ((v & 32'h0000_0FFF) << 20);
        end else begin
            w = w | (32'(s2) << 20)
                  | (((v >> 1)  & 32'h0000_000F) << 8)
                  | (((v >> 11) & 32'h0000_0001) << 7)
                  | (((v >> 5)  & 32'h0000_003F) << 25)
                  | (((v >> 12) & 32'h0000_0001) << 31);
        end
        return w;
    endfunction

    task automatic model_step();
        bit          acc;
        logic [31:0] w;
        acc = bus.in_valid && m_ready;
        if (rst) begin
            m_started = 1'b0; m_closed = 1'b0; m_count = 0; m_we = 1'b0;
            m_addr = BASE; m_wdata = 32'h0; m_err = 1'b0; m_cks = 32'h0;
        end else begin
            m_we = 1'b0;
            if (bus.start && (!m_started || m_closed)) begin
                m_started = 1'b1; m_closed = 1'b0; m_count = 0; m_err = 1'b0;
                m_addr = BASE; m_cks = 32'h0;
            end else if (m_started && !m_closed) begin
                if (acc) begin
                    if (legal(bus.ImmSrc, bus.imm)) begin
                        w       = encode(bus.ImmSrc, bus.imm, bus.opcode, bus.rd, bus.funct3,
                                         bus.rs1, bus.rs2);
                        m_we    = 1'b1;
                        m_addr  = BASE + 32'(4 * m_count);
                        m_wdata = w;
                        m_count = m_count + 1;
                        m_cks   = {m_cks[30:0], m_cks[31]} ^ w;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (bus.finish) m_closed = 1'b1;
            end
        end
        m_ready = m_started && !m_closed && (m_count < DEPTH);
        m_done  = m_started && m_closed;
        m_full  = (m_count == DEPTH);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("in_ready",   64'(bus.in_ready),   64'(m_ready));
        chk("mem_we",     64'(bus.mem_we),     64'(m_we));
        chk("mem_addr",   64'(bus.mem_addr),   64'(m_addr));
        chk("mem_wdata",  64'(bus.mem_wdata),  64'(m_wdata));
        chk("word_count", 64'(bus.word_count), 64'(m_count));
        chk("full",       64'(bus.full),       64'(m_full));
        chk("imm_err",    64'(bus.imm_err),    64'(m_err));
        chk("done",       64'(bus.done),       64'(m_done));
`ifdef IMM_ENCODE_CHECKSUM_EN
        chk("checksum",   64'(bus.checksum),   64'(m_cks));
`endif
    endtask

    // Drive one cycle of control inputs, advance the model, then compare after the edge.
    task automatic cyc(input bit r, input bit s, input bit f, input bit v);
        rst = r; bus.start = s; bus.finish = f; bus.in_valid = v;
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic set_i(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                         input logic [4:0] s1, input int v);
        bus.ImmSrc = 1'b1; bus.opcode = op; bus.rd = d; bus.funct3 = f3;
        bus.rs1 = s1; bus.rs2 = 5'd0; bus.imm = 32'(v);
    endtask

    task automatic set_b(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] s1,
                         input logic [4:0] s2, input int v);
        bus.ImmSrc = 1'b0; bus.opcode = op; bus.rd = 5'd0; bus.funct3 = f3;
        bus.rs1 = s1; bus.rs2 = s2; bus.imm = 32'(v);
    endtask

    int edge_imm [10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098, 0};

    initial begin
        set_i(7'h13, 5'd0, 3'd0, 5'd0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_addr",  64'(bus.mem_addr), 64'(32'hBFC00000));
        chk("reset_ready", 64'(bus.in_ready), 64'd0);

        // Test 1 and 2: first I-type word then a back-to-back B-type word.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        set_i(7'h13, 5'd1, 3'd0, 5'd0, -1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_we",    64'(bus.mem_we),     64'd1);
        chk("t1_addr",  64'(bus.mem_addr),   64'(32'hBFC00000));
        chk("t1_wdata", 64'(bus.mem_wdata),  64'(32'hFFF00093));
        chk("t1_count", 64'(bus.word_count), 64'd1);
        set_b(7'h63, 3'd1, 5'd1, 5'd0, -4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_addr",  64'(bus.mem_addr),   64'(32'hBFC00004));
        chk("t2_wdata", 64'(bus.mem_wdata),  64'(32'hFE009EE3));
        chk("t2_count", 64'(bus.word_count), 64'd2);

        // Test 3: out-of-range immediates are consumed without a write.
        set_i(7'h13, 5'd2, 3'd0, 5'd3, 2048);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_we_i",  64'(bus.mem_we),  64'd0);
        chk("t3_err_i", 64'(bus.imm_err), 64'd1);
        set_b(7'h63, 3'd0, 5'd1, 5'd2, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_we_b",    64'(bus.mem_we),     64'd0);
        chk("t3_count_b", 64'(bus.word_count), 64'd2);
        set_i(7'h13, 5'd4, 3'd0, 5'd0, 5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_addr", 64'(bus.mem_addr), 64'(32'hBFC00008));
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_err_clr", 64'(bus.imm_err), 64'd0);

        // Test 4: five bundles offered with in_valid held; only DEPTH are taken.
        for (int i = 0; i < 5; i++) begin
            set_i(7'h13, 5'(i + 1), 3'd0, 5'd0, i);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("t4_full",  64'(bus.full),       64'd1);
        chk("t4_ready", 64'(bus.in_ready),   64'd0);
        chk("t4_count", 64'(bus.word_count), 64'd4);
        chk("t4_addr",  64'(bus.mem_addr),   64'(32'hBFC0000C));
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_done", 64'(bus.done), 64'd1);

        // Test 5: finish together with an accepted bundle.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        set_b(7'h63, 3'd0, 5'd5, 5'd6, 16);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_we",   64'(bus.mem_we), 64'd1);
        chk("t5_done", 64'(bus.done),   64'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_ready", 64'(bus.in_ready), 64'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_count", 64'(bus.word_count), 64'd0);
        chk("t5_addr",  64'(bus.mem_addr),   64'(32'hBFC00000));

        // Test 6: reset right after an acceptance drops the following bundle.
        set_i(7'h13, 5'd7, 3'd2, 5'd8, 100);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_we",    64'(bus.mem_we),    64'd0);
        chk("t6_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("t6_ready", 64'(bus.in_ready),  64'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_done", 64'(bus.done), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int v;
            case ($urandom_range(0, 4))
                0:       v = int'($urandom());
                1:       v = int'($urandom_range(0, 4095)) - 2048;
                2:       v = int'($urandom_range(0, 8191)) - 4096;
                3:       v = edge_imm[$urandom_range(0, 9)];
                default: v = int'($urandom_range(0, 9000)) - 4500;
            endcase
            bus.ImmSrc = 1'($urandom_range(0, 1));
            bus.opcode = 7'($urandom());
            bus.rd     = 5'($urandom());
            bus.funct3 = 3'($urandom());
            bus.rs1    = 5'($urandom());
            bus.rs2    = 5'($urandom());
            bus.imm    = 32'(v);
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 14) == 0),
                ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
